// File: rtl/serial_parallel_rx.sv
// rtl/serial_parallel_rx.sv - serial lane deserializer with comma alignment and lock FSM
// Optional SP_RX_CNT_EN adds a saturating count of delivered data bytes on rx_cnt.
module serial_parallel_rx #(
    parameter logic [7:0]  COMMA     = 8'hBC,
    parameter int unsigned COMMA_CNT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_in,
    output logic [7:0]  data_out,
    output logic        valid_out,
`ifdef SP_RX_CNT_EN
    output logic [15:0] rx_cnt,
`endif
    output logic        active
);

    typedef enum logic [1:0] {
        HUNT,
        ALIGN,
        LOCKED
    } state_t;

    localparam logic [3:0] CNT_TARGET = 4'(COMMA_CNT);

    state_t     state_q;
    state_t     state_d;
    logic [7:0] sr_q;
    logic [2:0] ph_q;
    logic [2:0] ph_d;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic [7:0] data_d;
    logic       valid_d;
    logic       is_comma;
    logic       boundary;

    assign is_comma = (sr_q == COMMA);
    assign boundary = (ph_q == 3'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_q <= 8'h00;
        end else begin
            sr_q <= {sr_q[6:0], data_in};
        end
    end

    // A comma seen while hunting fixes the byte phase: this cycle is a boundary.
    always_comb begin
        state_d = state_q;
        ph_d    = ph_q + 3'd1;
        cnt_d   = cnt_q;
        data_d  = data_out;
        valid_d = 1'b0;
        case (state_q)
            HUNT: begin
                if (is_comma) begin
                    ph_d    = 3'd1;
                    cnt_d   = 4'd1;
                    state_d = (CNT_TARGET == 4'd1) ? LOCKED : ALIGN;
                end
            end
            ALIGN: begin
                if (boundary) begin
                    if (is_comma) begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_d == CNT_TARGET) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        cnt_d   = 4'd0;
                        state_d = HUNT;
                    end
                end
            end
            LOCKED: begin
                if (boundary && !is_comma) begin
                    data_d  = sr_q;
                    valid_d = 1'b1;
                end
            end
            default: begin
                state_d = HUNT;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= HUNT;
            ph_q      <= 3'd0;
            cnt_q     <= 4'd0;
            data_out  <= 8'h00;
            valid_out <= 1'b0;
            active    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ph_q      <= ph_d;
            cnt_q     <= cnt_d;
            data_out  <= data_d;
            valid_out <= valid_d;
            active    <= (state_d == LOCKED);
        end
    end

`ifdef SP_RX_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_cnt <= 16'h0000;
        end else if (valid_d && (rx_cnt != 16'hFFFF)) begin
            rx_cnt <= rx_cnt + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_serial_parallel_rx.sv
// tb/tb_serial_parallel_rx.sv - randomized bench for serial_parallel_rx against a bit-history model
module tb_serial_parallel_rx;

    localparam logic [7:0] COMMA     = 8'hBC;
    localparam int         COMMA_CNT = 4;

    logic       clk     = 1'b0;
    logic       reset   = 1'b0;
    logic       data_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;
`ifdef SP_RX_CNT_EN
    logic [15:0] rx_cnt;
`endif

    always #5 clk = ~clk;

    serial_parallel_rx #(
        .COMMA     (COMMA),
        .COMMA_CNT (COMMA_CNT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_out (valid_out),
`ifdef SP_RX_CNT_EN
        .rx_cnt    (rx_cnt),
`endif
        .active    (active)
    );

    int checks  = 0;
    int errors  = 0;
    int strobes = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: last eight received bits plus the absolute edge index of the next byte boundary.
    bit         hist[$];
    int         k;
    int         nb;
    bit         m_align;
    bit         m_locked;
    int         m_cnt;
    logic [7:0] m_data;
    bit         m_valid;
    int         m_rxcnt;

    function automatic logic [7:0] window();
        logic [7:0] w = 8'h00;
        for (int i = 0; i < 8; i++) w = {w[6:0], hist[i]};
        return w;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < 8; i++) hist.push_back(1'b0);
        k = 0; nb = 0; m_align = 0; m_locked = 0; m_cnt = 0;
        m_data = 8'h00; m_valid = 0; m_rxcnt = 0;
    endtask

    task automatic model_edge(input bit b);
        logic [7:0] w;
        w = window();
        m_valid = 0;
        if (m_locked) begin
            if (k == nb) begin
                nb += 8;
                if (w != COMMA) begin
                    m_data  = w;
                    m_valid = 1;
                    if (m_rxcnt < 65535) m_rxcnt++;
                end
            end
        end else if (m_align) begin
            if (k == nb) begin
                if (w == COMMA) begin
                    m_cnt++;
                    nb += 8;
                    if (m_cnt == COMMA_CNT) begin
                        m_locked = 1;
                        m_align  = 0;
                    end
                end else begin
                    m_align = 0;
                    m_cnt   = 0;
                end
            end
        end else if (w == COMMA) begin
            m_cnt = 1;
            nb    = k + 8;
            if (COMMA_CNT == 1) m_locked = 1;
            else m_align = 1;
        end
        hist.push_back(b);
        void'(hist.pop_front());
        k++;
    endtask

    task automatic check_outputs(input string pfx);
        check_val({pfx, "_data_out"}, 32'(data_out), 32'(m_data));
        check_val({pfx, "_valid_out"}, 32'(valid_out), 32'(m_valid));
        check_val({pfx, "_active"}, 32'(active), 32'(m_locked));
`ifdef SP_RX_CNT_EN
        check_val({pfx, "_rx_cnt"}, 32'(rx_cnt), 32'(m_rxcnt));
`endif
    endtask

    task automatic step(input bit b);
        data_in = b;
        @(posedge clk);
        model_edge(b);
        @(negedge clk);
        if (valid_out) strobes++;
        check_outputs("step");
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) step(v[i]);
    endtask

    task automatic send_data();
        logic [7:0] v;
        do v = 8'($urandom); while (v == COMMA);
        send_byte(v);
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < cycles; i++) begin
            data_in = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            check_outputs("rst");
        end
        reset   = 1'b1;
        strobes = 0;
    endtask

    initial begin
        @(negedge clk);
        do_reset(5);

        // aligned commas from reset release; lock shows one clk after the 4th boundary
        for (int i = 0; i < 4; i++) send_byte(COMMA);
        check_val("lock_pending", 32'(active), 32'd0);
        step(COMMA[7]);
        check_val("lock_active", 32'(active), 32'd1);
        for (int i = 6; i >= 0; i--) step(COMMA[i]);
        send_byte(8'hA5);
        send_byte(8'h3C);
        send_byte(COMMA);
        check_val("idle_hold", 32'(data_out), 32'h3C);
        send_byte(8'h0F);
        send_byte(COMMA);
        check_val("strobe_count", 32'(strobes), 32'd3);
        check_val("last_data", 32'(data_out), 32'h0F);

        // lock at a 3-bit offset
        do_reset(2);
        for (int i = 0; i < 3; i++) step(1'($urandom));
        for (int i = 0; i < 5; i++) send_byte(COMMA);
        send_byte(8'hA5);
        send_byte(COMMA);
        check_val("offset_data", 32'(data_out), 32'hA5);
        check_val("offset_strobes", 32'(strobes), 32'd1);

        // alignment broken by a data byte, then relock
        do_reset(2);
        send_byte(COMMA);
        send_byte(COMMA);
        send_byte(8'h5A);
        step(1'b1);
        check_val("realign_inactive", 32'(active), 32'd0);
        for (int i = 6; i >= 0; i--) step(COMMA[i]);
        for (int i = 0; i < 3; i++) send_byte(COMMA);
        step(COMMA[7]);
        check_val("relock_active", 32'(active), 32'd1);

`ifdef SP_RX_CNT_EN
        do_reset(2);
        for (int i = 0; i < 4; i++) send_byte(COMMA);
        for (int i = 0; i < 10; i++) send_data();
        send_byte(COMMA);
        check_val("rx_cnt_ten", 32'(rx_cnt), 32'd10);
        for (int i = 0; i < 3; i++) step(1'($urandom));
        do_reset(1);
        check_val("rx_cnt_cleared", 32'(rx_cnt), 32'd0);
`endif

        // randomized sessions with slips, idles and mid-byte resets
        for (int r = 0; r < 30; r++) begin
            do_reset(1 + int'($urandom_range(0, 3)));
            for (int i = 0; i < int'($urandom_range(0, 7)); i++) step(1'($urandom));
            for (int i = 0; i < COMMA_CNT + int'($urandom_range(0, 2)); i++) send_byte(COMMA);
            for (int i = 0; i < 20; i++) begin
                if ($urandom_range(0, 3) == 0) send_byte(COMMA);
                else send_data();
            end
            for (int i = 0; i < int'($urandom_range(0, 7)); i++) step(1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
